seq_chk_test: RTL and testbench
===============================

# seq_chk_test

Serial test-pattern checker: receives the 1-bit stream from the test sequence generator and aligns to the repeating pattern. It verifies every valid bit against the expected value and reports lock status and bit errors. It sits at the receive end of the loopback/link under test, so a single bench can close the generator→link→checker path.

## Interface
- `PATTERN`, 0: expected pattern. 0 = "101" repeating (period P=3). 1 = "1010" repeating (period P=4). First bit of each period is phase 0.
- `LOCK_CNT`, 8: consecutive matching bits in VERIFY required to declare lock. Must be ≥1.
- `LOSS_CNT`, 4: consecutive mismatches in LOCKED that drop lock. Must be ≥1.
- `ERR_W`, 16: error counter width.

- `clk`  in  1  single clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear of `err_cnt`; lock state is unaffected.
- `data_in`  in  1  serial data bit.
- `data_in_valid`  in  1  qualifies `data_in`; only valid cycles are examined.
- `locked`  out  1  high while in LOCKED.
- `err_pulse`  out  1  one-cycle pulse per mismatching bit while LOCKED.
- `err_cnt`  out  ERR_W  mismatches counted while LOCKED; saturates at all-ones.

## Operation
- States are HUNT, VERIFY and LOCKED. Reset state is HUNT.
- Expected bit: PAT[phase]. Pattern 0 is PAT = {1,0,1}. Pattern 1 is PAT = {1,0,1,0}.
- HUNT:
  - Each valid bit shifts into a P-bit window; a fill counter saturates at P.
  - Once the window is full, compare it against the P rotations. The window matches rotation k when the oldest bit equals PAT[k] and each later bit equals the next PAT entry, mod P.
  - On the smallest matching k, load phase = k and go to VERIFY.
  - Otherwise keep shifting.
  - Mismatches in HUNT are not counted.
- VERIFY:
  - Each valid bit is compared with PAT[phase], and phase advances mod P.
  - A match increments the match counter. When it reaches LOCK_CNT, go to LOCKED and clear the counter.
  - Any mismatch returns to HUNT and clears the window, fill counter and match counter.
- LOCKED:
  - Each valid bit is compared with PAT[phase], and phase advances mod P on every valid bit, match or not. There is no bit slip.
  - On a mismatch: `err_pulse`=1, `err_cnt` increments (saturating), and the loss counter increments.
  - On a match, the loss counter clears.
  - When the loss counter reaches LOSS_CNT, go to HUNT with the loss counter cleared.
- When `data_in_valid`=0, no state, phase, window or counter changes, and `err_pulse`=0. Gaps of any length are tolerated.
- `clr` together with an error in the same cycle: the clear wins and `err_cnt`=0. `err_pulse` still fires.
- Counter widths are $clog2(max+1) for the match and loss counters, and 2 bits for phase.

## Timing
- All outputs are registered.
- Reset values: `locked`=0, `err_pulse`=0, `err_cnt`=0. Phase, window, fill, match and loss counters are also 0, and the state is HUNT.
- Error latency: the bad bit is sampled at edge t; `err_pulse` is high and `err_cnt` is updated in the cycle following edge t.
- Lock latency on a clean continuous stream: `locked` rises at the edge sampling valid bit number P+LOCK_CNT. That is bit 11 for PATTERN=0 and bit 12 for PATTERN=1 with defaults.
- Unlock: `locked` falls at the edge sampling the LOSS_CNT-th consecutive bad bit. That bit still produces `err_pulse` and is counted.
- Reset mid-operation: outputs clear asynchronously, and lock must be re-acquired from HUNT.

## Structure
- Shared package `seq_test_pkg` holds:
  - pattern period constants (3, 4);
  - pattern bit vectors `PAT0`=3'b101 and `PAT1`=4'b1010;
  - a function returning P from PATTERN;
  - the checker state typedef (HUNT, VERIFY, LOCKED).
- One sub-module is natural: `seq_chk_align`, covering the HUNT window, fill counter and rotation compare. Outputs are `align_hit` and `align_phase`. The FSM, phase and counters stay in `seq_chk_test`.

## Test plan
- Reset, then feed a continuous clean PATTERN=0 stream 1,0,1,1,0,1,… → `locked` rises at the edge of valid bit 11; `err_cnt`=0 and `err_pulse` never asserts.
- PATTERN=1, stream starting at phase 1 (0,1,0,1,…) with `data_in_valid` toggling 1,0,1,0 → lock after 12 valid bits (24 cycles); gaps cause no errors.
- Locked PATTERN=0, flip one bit → a single `err_pulse` one cycle later; `err_cnt`=1; `locked` stays 1. Assert `clr` → `err_cnt`=0.
- Locked, corrupt 4 consecutive bits → `err_cnt`=4, and `locked` falls at the 4th bad bit. A clean stream relocks after 3+8 valid bits.
- In VERIFY, one mismatch at match count 5 → returns to HUNT, `locked` stays 0, `err_cnt` unchanged. Force `err_cnt` to saturate with ERR_W=2 → holds at 3.
- Assert `rst` while LOCKED with `err_cnt`=7 → `locked`=0 and `err_cnt`=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/seq_test_pkg.sv
// Shared definitions for the test sequence generator and checker:
// pattern periods, pattern bit vectors, helpers and the checker state type.
package seq_test_pkg;

    localparam int P0_LEN = 3;
    localparam int P1_LEN = 4;

    // Bit vectors are written first-bit-first: the MSB is phase 0.
    localparam logic [2:0] PAT0 = 3'b101;
    localparam logic [3:0] PAT1 = 4'b1010;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    // Pattern period for a given pattern selector.
    function automatic int pat_len(input int pattern);
        return (pattern == 0) ? P0_LEN : P1_LEN;
    endfunction

    // Expected bit at a given phase of the selected pattern.
    function automatic logic pat_bit(input int pattern, input int idx);
        logic [1:0] i2;
        i2 = idx[1:0];
        if (pattern == 0) begin
            return PAT0[2'd2 - i2];
        end
        return PAT1[2'd3 - i2];
    endfunction

endpackage

// File: rtl/seq_chk_align.sv
// HUNT-state alignment: shifts valid bits into a one-period window and
// reports which pattern rotation the window (including the incoming bit)
// matches, so the checker can leave HUNT on the same edge the window fills.
module seq_chk_align
    import seq_test_pkg::*;
#(
    parameter int PATTERN = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hunt_en,
    input  logic       data_in,
    input  logic       data_in_valid,
    output logic       align_hit,
    output logic [1:0] align_phase
);

    localparam int P      = pat_len(PATTERN);
    localparam int FILL_W = $clog2(P + 1);

    logic [P-1:0]      window_q;
    logic [P-1:0]      window_next;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_next;
    logic              rot_match;

    // Candidate window and saturating fill count after accepting the current bit.
    always_comb begin
        window_next = {window_q[P-2:0], data_in};
        fill_next   = (fill_q == FILL_W'(P)) ? fill_q : fill_q + 1'b1;
    end

    // Window only collects while hunting; leaving HUNT flushes it so every hunt starts empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (!hunt_en) begin
            window_q <= '0;
            fill_q   <= '0;
        end else if (data_in_valid) begin
            window_q <= window_next;
            fill_q   <= fill_next;
        end
    end

    // Rotation compare; k is scanned downwards so the smallest matching rotation wins.
    always_comb begin
        align_hit   = 1'b0;
        align_phase = 2'd0;
        rot_match   = 1'b0;
        if (hunt_en && data_in_valid && (fill_next == FILL_W'(P))) begin
            for (int k = P - 1; k >= 0; k--) begin
                rot_match = 1'b1;
                for (int i = 0; i < P; i++) begin
                    if (window_next[P-1-i] != pat_bit(PATTERN, (k + i) % P)) begin
                        rot_match = 1'b0;
                    end
                end
                if (rot_match) begin
                    align_hit   = 1'b1;
                    align_phase = 2'(k);
                end
            end
        end
    end

endmodule

// File: rtl/seq_chk_test.sv
// Serial test-pattern checker: aligns to the repeating pattern, verifies
// lock over LOCK_CNT bits, then counts bit errors while locked and drops
// lock after LOSS_CNT consecutive bad bits.
module seq_chk_test
    import seq_test_pkg::*;
#(
    parameter int PATTERN  = 0,
    parameter int LOCK_CNT = 8,
    parameter int LOSS_CNT = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             data_in,
    input  logic             data_in_valid,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int P       = pat_len(PATTERN);
    localparam int MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int LOSS_W  = $clog2(LOSS_CNT + 1);

    chk_state_t         state_q;
    chk_state_t         state_next;
    logic [1:0]         phase_q;
    logic [1:0]         phase_next;
    logic [1:0]         phase_inc;
    logic [MATCH_W-1:0] match_q;
    logic [MATCH_W-1:0] match_next;
    logic [LOSS_W-1:0]  loss_q;
    logic [LOSS_W-1:0]  loss_next;
    logic [ERR_W-1:0]   err_cnt_next;
    logic               err_pulse_next;
    logic               bit_ok;
    logic               align_hit;
    logic [1:0]         align_phase;

    seq_chk_align #(
        .PATTERN(PATTERN)
    ) u_align (
        .clk          (clk),
        .rst          (rst),
        .hunt_en      (state_q == HUNT),
        .data_in      (data_in),
        .data_in_valid(data_in_valid),
        .align_hit    (align_hit),
        .align_phase  (align_phase)
    );

    // Compare the incoming bit with the expected bit and precompute the wrapped next phase.
    always_comb begin
        bit_ok    = (data_in == pat_bit(PATTERN, int'(phase_q)));
        phase_inc = (phase_q == 2'(P - 1)) ? 2'd0 : phase_q + 2'd1;
    end

    // Next-state and counter logic; nothing moves on invalid cycles except the clear.
    always_comb begin
        state_next     = state_q;
        phase_next     = phase_q;
        match_next     = match_q;
        loss_next      = loss_q;
        err_cnt_next   = err_cnt;
        err_pulse_next = 1'b0;
        if (data_in_valid) begin
            case (state_q)
                HUNT: begin
                    if (align_hit) begin
                        state_next = VERIFY;
                        phase_next = align_phase;
                        match_next = '0;
                    end
                end
                VERIFY: begin
                    phase_next = phase_inc;
                    if (bit_ok) begin
                        if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
                            state_next = LOCKED;
                            match_next = '0;
                        end else begin
                            match_next = match_q + 1'b1;
                        end
                    end else begin
                        state_next = HUNT;
                        match_next = '0;
                    end
                end
                LOCKED: begin
                    phase_next = phase_inc;
                    if (!bit_ok) begin
                        err_pulse_next = 1'b1;
                        if (err_cnt != '1) begin
                            err_cnt_next = err_cnt + 1'b1;
                        end
                        if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
                            state_next = HUNT;
                            loss_next  = '0;
                        end else begin
                            loss_next = loss_q + 1'b1;
                        end
                    end else begin
                        loss_next = '0;
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
        if (clr) begin
            err_cnt_next = '0;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= HUNT;
            phase_q   <= 2'd0;
            match_q   <= '0;
            loss_q    <= '0;
            err_cnt   <= '0;
            err_pulse <= 1'b0;
            locked    <= 1'b0;
        end else begin
            state_q   <= state_next;
            phase_q   <= phase_next;
            match_q   <= match_next;
            loss_q    <= loss_next;
            err_cnt   <= err_cnt_next;
            err_pulse <= err_pulse_next;
            locked    <= (state_next == LOCKED);
        end
    end

endmodule

// File: tb/tb_seq_chk_test.sv
// Bench for seq_chk_test: three instances (pattern 0 defaults, pattern 1,
// pattern 0 with a 2-bit error counter). Lock edges and error pulses of the
// main instance are checked through an expected-event queue.
module tb_seq_chk_test;

    localparam int EV_ERR  = 0;
    localparam int EV_UP   = 1;
    localparam int EV_DOWN = 2;

    typedef struct {
        int kind;
        int edge_no;
        int cnt;
    } ev_t;

    logic clk;
    logic rst;
    logic v0, d0, c0, v1, d1, c1, v2, d2, c2;
    logic locked0, pulse0, locked1, pulse1, locked2, pulse2;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;

    int   checks   = 0;
    int   failures = 0;
    int   edges    = 0;
    int   ph[3];
    logic prev_locked = 1'b0;
    ev_t  evq[$];

    seq_chk_test #(.PATTERN(0)) dut0 (
        .clk(clk), .rst(rst), .clr(c0), .data_in(d0), .data_in_valid(v0),
        .locked(locked0), .err_pulse(pulse0), .err_cnt(cnt0)
    );

    seq_chk_test #(.PATTERN(1)) dut1 (
        .clk(clk), .rst(rst), .clr(c1), .data_in(d1), .data_in_valid(v1),
        .locked(locked1), .err_pulse(pulse1), .err_cnt(cnt1)
    );

    seq_chk_test #(.PATTERN(0), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .clr(c2), .data_in(d2), .data_in_valid(v2),
        .locked(locked2), .err_pulse(pulse2), .err_cnt(cnt2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Number the rising edges so expected events can name the edge they belong to.
    always @(posedge clk) begin
        edges++;
    end

    function automatic logic pat0(input int p);
        return (p == 1) ? 1'b0 : 1'b1;
    endfunction

    function automatic logic pat1(input int p);
        return (p % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs into the selected instance, then park all inputs low.
    task automatic applyStimulus(input int inst, input logic v, input logic d, input logic c);
        v0 = (inst == 0) ? v : 1'b0;
        d0 = (inst == 0) ? d : 1'b0;
        c0 = (inst == 0) ? c : 1'b0;
        v1 = (inst == 1) ? v : 1'b0;
        d1 = (inst == 1) ? d : 1'b0;
        c1 = (inst == 1) ? c : 1'b0;
        v2 = (inst == 2) ? v : 1'b0;
        d2 = (inst == 2) ? d : 1'b0;
        c2 = (inst == 2) ? c : 1'b0;
        @(negedge clk);
        {v0, d0, c0, v1, d1, c1, v2, d2, c2} = '0;
    endtask

    // Send the next pattern bit of an instance's stream, optionally inverted.
    task automatic sendBit(input int inst, input logic bad, input logic c);
        logic b;
        b = (inst == 1) ? pat1(ph[inst]) : pat0(ph[inst]);
        applyStimulus(inst, 1'b1, b ^ bad, c);
        ph[inst] = (ph[inst] + 1) % ((inst == 1) ? 4 : 3);
    endtask

    // Expect an event on the edge that samples the next driven bit.
    task automatic expectEv(input int kind, input int cnt);
        ev_t e;
        e.kind    = kind;
        e.edge_no = edges + 1;
        e.cnt     = cnt;
        evq.push_back(e);
    endtask

    task automatic cleanRun0(input int n, input int lock_at, input int cnt);
        for (int i = 1; i <= n; i++) begin
            if (i == lock_at) expectEv(EV_UP, cnt);
            sendBit(0, 1'b0, 1'b0);
        end
    endtask

    task automatic popCheck(input int kind, input int cnt);
        ev_t e;
        checks++;
        if (evq.size() == 0) begin
            failures++;
            $display("[TB] FAIL sb_unexpected kind=%0d edge=%0d cnt=%0d required=no_event", kind, edges, cnt);
        end else begin
            e = evq.pop_front();
            if (e.kind != kind || e.edge_no != edges || e.cnt != cnt) begin
                failures++;
                $display("[TB] FAIL sb_event actual kind=%0d edge=%0d cnt=%0d required kind=%0d edge=%0d cnt=%0d",
                         kind, edges, cnt, e.kind, e.edge_no, e.cnt);
            end
        end
    endtask

    // Monitor for the main instance: every error pulse and lock transition must match the queue head.
    always @(negedge clk) begin
        if (rst) begin
            prev_locked = 1'b0;
        end else begin
            if (pulse0) popCheck(EV_ERR, int'(cnt0));
            if (locked0 != prev_locked) begin
                popCheck(locked0 ? EV_UP : EV_DOWN, int'(cnt0));
                prev_locked = locked0;
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence.
    initial begin
        ph[0] = 0;
        ph[1] = 1;
        ph[2] = 0;
        rst = 1'b1;
        {v0, d0, c0, v1, d1, c1, v2, d2, c2} = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_locked", int'(locked0), 0);
        checkOutput("reset_pulse", int'(pulse0), 0);
        checkOutput("reset_cnt", int'(cnt0), 0);
        rst = 1'b0;
        @(negedge clk);

        // Clean pattern-0 stream locks on valid bit 11.
        cleanRun0(11, 11, 0);
        checkOutput("lock0_up", int'(locked0), 1);
        cleanRun0(4, 0, 0);

        // Single flipped bit while locked.
        expectEv(EV_ERR, 1);
        sendBit(0, 1'b1, 1'b0);
        checkOutput("single_err_cnt", int'(cnt0), 1);
        checkOutput("single_err_pulse", int'(pulse0), 1);
        cleanRun0(1, 0, 0);
        checkOutput("pulse_one_cycle", int'(pulse0), 0);
        checkOutput("still_locked", int'(locked0), 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_cnt", int'(cnt0), 0);

        // Four consecutive bad bits drop lock on the fourth; relock after 3+8 clean bits.
        for (int i = 1; i <= 4; i++) begin
            expectEv(EV_ERR, i);
            if (i == 4) expectEv(EV_DOWN, 4);
            sendBit(0, 1'b1, 1'b0);
        end
        checkOutput("loss_cnt", int'(cnt0), 4);
        cleanRun0(11, 11, 4);

        // Lose lock again, then break VERIFY after five matches.
        for (int i = 5; i <= 8; i++) begin
            expectEv(EV_ERR, i);
            if (i == 8) expectEv(EV_DOWN, 8);
            sendBit(0, 1'b1, 1'b0);
        end
        cleanRun0(8, 0, 0);
        sendBit(0, 1'b1, 1'b0);
        checkOutput("verify_miss_locked", int'(locked0), 0);
        checkOutput("verify_miss_cnt", int'(cnt0), 8);
        cleanRun0(11, 11, 8);

        // Seven isolated errors, then asynchronous reset in mid-cycle.
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            expectEv(EV_ERR, i);
            sendBit(0, 1'b1, 1'b0);
            cleanRun0(2, 0, 0);
        end
        checkOutput("cnt_seven", int'(cnt0), 7);
        checkOutput("locked_before_rst", int'(locked0), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_locked", int'(locked0), 0);
        checkOutput("async_rst_cnt", int'(cnt0), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cleanRun0(11, 11, 0);

        // Pattern 1 from phase 1 with a gap after every valid bit.
        for (int n = 1; n <= 12; n++) begin
            sendBit(1, 1'b0, 1'b0);
            checkOutput($sformatf("p1_locked_bit%0d", n), int'(locked1), (n >= 12) ? 1 : 0);
            checkOutput("p1_no_pulse", int'(pulse1), 0);
            applyStimulus(1, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("p1_cnt", int'(cnt1), 0);

        // Two-bit counter saturates at 3; clear beats a same-cycle error.
        for (int n = 1; n <= 11; n++) sendBit(2, 1'b0, 1'b0);
        checkOutput("sat_locked", int'(locked2), 1);
        for (int i = 1; i <= 4; i++) begin
            sendBit(2, 1'b1, 1'b0);
            checkOutput($sformatf("sat_cnt_err%0d", i), int'(cnt2), (i > 3) ? 3 : i);
            checkOutput("sat_pulse", int'(pulse2), 1);
            sendBit(2, 1'b0, 1'b0);
        end
        sendBit(2, 1'b1, 1'b1);
        checkOutput("clr_wins_cnt", int'(cnt2), 0);
        checkOutput("clr_wins_pulse", int'(pulse2), 1);
        checkOutput("clr_keeps_lock", int'(locked2), 1);

        repeat (2) @(negedge clk);
        checkOutput("sb_drained", evq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
